// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
//   Single-stage registered RV32I decoder with valid/ready handshaking on both
//   sides. One word is captured per in_valid && in_ready; its decoded fields
//   and control bits are held on out_* until downstream takes them. Illegal
//   words still flow through, flagged by out_illegal, and are counted in a
//   saturating counter.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_ready = !out_valid || out_ready
//   in_instr, in_pc       instruction word and its address
//   flush                 drop the held result and ignore this cycle's word
//   out_valid/out_ready   downstream handshake
//   out_pc .. out_imm     registered decode fields
//   out_alu_op            0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA
//                         8 OR 9 AND 10 PASS_B
//   out_reg_write ..      registered control bits, out_illegal flag
//   illegal_count         saturating count of accepted illegal words
// -----------------------------------------------------------------------------
module instr_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [31:0]      out_imm,
  output logic [3:0]       out_alu_op,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_alu_src_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src_imm;
    logic        illegal;
  } dec_t;

  dec_t             dec, res_d, res_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ill;
  logic             accept;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};

  // Combinational decode of the word currently on in_instr.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    dec        = '0;
    ill        = 1'b0;
    dec.pc     = in_pc;
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct3 = f3;
    dec.alu_op = ALU_ADD;

    unique case (opcode)
      7'b0110011: begin // R-type
        dec.reg_write = 1'b1;
        unique case ({f7, f3})
          {7'b0000000, 3'b000}: dec.alu_op = ALU_ADD;
          {7'b0000000, 3'b001}: dec.alu_op = ALU_SLL;
          {7'b0000000, 3'b010}: dec.alu_op = ALU_SLT;
          {7'b0000000, 3'b011}: dec.alu_op = ALU_SLTU;
          {7'b0000000, 3'b100}: dec.alu_op = ALU_XOR;
          {7'b0000000, 3'b101}: dec.alu_op = ALU_SRL;
          {7'b0000000, 3'b110}: dec.alu_op = ALU_OR;
          {7'b0000000, 3'b111}: dec.alu_op = ALU_AND;
          {7'b0100000, 3'b000}: dec.alu_op = ALU_SUB;
          {7'b0100000, 3'b101}: dec.alu_op = ALU_SRA;
          default:              ill = 1'b1;
        endcase
      end
      7'b0010011: begin // I-ALU; imm[11:5] only qualifies the shifts
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = imm_i;
        unique case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b001: begin
            dec.alu_op = ALU_SLL;
            ill        = (f7 != 7'b0000000);
          end
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b101: begin
            if (f7 == 7'b0000000)      dec.alu_op = ALU_SRL;
            else if (f7 == 7'b0100000) dec.alu_op = ALU_SRA;
            else                       ill = 1'b1;
          end
          3'b110: dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
      end
      7'b0000011: begin // LOAD
        dec.reg_write   = 1'b1;
        dec.mem_read    = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = imm_i;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin // STORE
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = imm_s;
        ill = (f3 > 3'b010);
      end
      7'b1100011: begin // BRANCH compares via subtraction
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        dec.imm    = imm_b;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b1101111: begin // JAL
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_j;
      end
      7'b1100111: begin // JALR
        dec.jump        = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = imm_i;
        ill = (f3 != 3'b000);
      end
      7'b0110111: begin // LUI passes the U immediate straight through
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.alu_op      = ALU_PASS_B;
        dec.imm         = imm_u;
      end
      default: ill = 1'b1;
    endcase

    // Illegal words carry only their PC and the flag downstream.
    if (ill) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next state: flush wins over capture and over the counter update.
  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      res_d   = dec;
      if (dec.illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = res_q.pc;
  assign out_rd          = res_q.rd;
  assign out_rs1         = res_q.rs1;
  assign out_rs2         = res_q.rs2;
  assign out_funct3      = res_q.funct3;
  assign out_imm         = res_q.imm;
  assign out_alu_op      = res_q.alu_op;
  assign out_reg_write   = res_q.reg_write;
  assign out_mem_read    = res_q.mem_read;
  assign out_mem_write   = res_q.mem_write;
  assign out_branch      = res_q.branch;
  assign out_jump        = res_q.jump;
  assign out_alu_src_imm = res_q.alu_src_imm;
  assign out_illegal     = res_q.illegal;
  assign illegal_count   = cnt_q;

endmodule

// File: tb/tb_instr_decoder.sv
// -----------------------------------------------------------------------------
// tb_instr_decoder
//   Scoreboard bench for instr_decoder. The driver issues directed and random
//   words, decodes each accepted word with a reference model built from the
//   RV32I field rules, and queues the expectation. A separate monitor compares
//   the head of the queue whenever out_valid is high and retires it when it is
//   consumed or flushed. A small counter width makes saturation reachable.
// -----------------------------------------------------------------------------
module tb_instr_decoder;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]      in_instr, in_pc, out_pc, out_imm;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic [2:0]       out_funct3;
  logic [3:0]       out_alu_op;
  logic             out_reg_write, out_mem_read, out_mem_write, out_branch;
  logic             out_jump, out_alu_src_imm, out_illegal;
  logic [CNT_W-1:0] illegal_count;

  instr_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump),
    .out_alu_src_imm(out_alu_src_imm), .out_illegal(out_illegal),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        rw, mr, mw, br, jp, asi, ill;
  } exp_t;

  exp_t sb[$];
  int   mdl_cnt  = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ALU op for R/I-ALU: the base op comes from funct3; funct7=0100000 selects
  // the alternate form (SUB for R-type 000, SRA for 101).
  function automatic bit alu_lookup(input logic [2:0] f3, input logic [6:0] f7,
                                    input bit is_imm, output logic [3:0] op);
    logic [3:0] base [8];
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    op = 4'd0;
    if (is_imm && f3 != 3'd1 && f3 != 3'd5) begin
      op = base[f3];
      return 1'b1;
    end
    if (f7 == 7'h00) begin
      op = base[f3];
      return 1'b1;
    end
    if (f7 == 7'h20 && (f3 == 3'd5 || (f3 == 3'd0 && !is_imm))) begin
      op = (f3 == 3'd0) ? 4'd1 : 4'd7;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t        e;
    int          s;
    logic [31:0] sgn;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    bit          legal;
    logic [3:0]  op;
    s     = int'(w);
    sgn   = (w[31]) ? 32'hFFFF_FFFF : 32'h0;
    imm_i = 32'(s >>> 20);
    imm_s = (32'(s >>> 25) << 5) | 32'(w[11:7]);
    imm_b = (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    imm_j = (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    imm_u = w & 32'hFFFF_F000;

    e = '{pc: pc, rd: w[11:7], rs1: w[19:15], rs2: w[24:20], f3: w[14:12],
          imm: 32'h0, alu: 4'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0,
          jp: 1'b0, asi: 1'b0, ill: 1'b0};
    legal = 1'b1;
    case (w[6:0])
      7'h33: begin legal = alu_lookup(w[14:12], w[31:25], 1'b0, op); e.alu = op; e.rw = 1; end
      7'h13: begin legal = alu_lookup(w[14:12], w[31:25], 1'b1, op); e.alu = op;
                   e.rw = 1; e.asi = 1; e.imm = imm_i; end
      7'h03: begin legal = !(w[14:12] inside {3'd3, 3'd6, 3'd7});
                   e.rw = 1; e.mr = 1; e.asi = 1; e.imm = imm_i; end
      7'h23: begin legal = (w[14:12] <= 3'd2); e.mw = 1; e.asi = 1; e.imm = imm_s; end
      7'h63: begin legal = !(w[14:12] inside {3'd2, 3'd3}); e.br = 1; e.alu = 4'd1; e.imm = imm_b; end
      7'h6F: begin e.jp = 1; e.rw = 1; e.imm = imm_j; end
      7'h67: begin legal = (w[14:12] == 3'd0); e.jp = 1; e.rw = 1; e.asi = 1; e.imm = imm_i; end
      7'h37: begin e.rw = 1; e.asi = 1; e.alu = 4'd10; e.imm = imm_u; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.ill = 1; e.rd = 0; e.alu = 0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0; e.asi = 0;
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic [31:0] w, input logic vld, input logic rdy, input logic fl);
    exp_t        e;
    logic        acc;
    logic        exp_rdy;
    logic [31:0] pc;
    @(negedge clk);
    pc        = $urandom & 32'hFFFF_FFFC;
    in_instr  = w;
    in_pc     = pc;
    in_valid  = vld;
    out_ready = rdy;
    flush     = fl;
    #1;
    exp_rdy = (sb.size() == 0) || rdy;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = vld && exp_rdy && !fl;
    e   = ref_decode(w, pc);
    @(posedge clk);
    #1;
    if (acc) begin
      sb.push_back(e);
      if (e.ill && mdl_cnt < CNT_MAX) mdl_cnt++;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [8];
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 8) w[6:0] = ops[k];
    k = $urandom_range(0, 3);
    if (k == 0)      w[31:25] = 7'h00;
    else if (k == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("illegal_count", 32'(illegal_count), 32'(mdl_cnt));
        if (out_valid && sb.size() != 0) begin
          exp_t e;
          e = sb[0];
          check("out_illegal", 32'(out_illegal), 32'(e.ill));
          check("out_pc", out_pc, e.pc);
          check("out_rd", 32'(out_rd), 32'(e.rd));
          check("out_alu_op", 32'(out_alu_op), 32'(e.alu));
          check("controls",
                32'({out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_src_imm}),
                32'({e.rw, e.mr, e.mw, e.br, e.jp, e.asi}));
          if (!e.ill) begin
            check("out_rs1", 32'(out_rs1), 32'(e.rs1));
            check("out_rs2", 32'(out_rs2), 32'(e.rs2));
            check("out_funct3", 32'(out_funct3), 32'(e.f3));
            check("out_imm", out_imm, e.imm);
          end
          if (out_ready || flush) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    #12;
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset illegal_count", 32'(illegal_count), 32'h0);
    check("reset out_rd", 32'(out_rd), 32'h0);
    check("reset controls", 32'({out_reg_write, out_jump, out_illegal, out_alu_op}), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Directed words.
    step(32'h0020_81B3, 1, 1, 0);          // add x3,x1,x2
    step(32'h4073_02B3, 1, 1, 0);          // sub x5,x6,x7
    step(32'hFFF0_0093, 1, 1, 0);          // addi x1,x0,-1
    step(32'hFFFF_FFFF, 1, 1, 0);          // illegal
    step(32'h0000_0000, 0, 1, 0);
    check("count after one illegal", 32'(illegal_count), 32'h1);

    // Backpressure: hold add for three cycles while sub waits.
    step(32'h0020_81B3, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(32'h4073_02B3, 1, 0, 0);
    step(32'h4073_02B3, 1, 1, 0);
    step(32'h0000_0000, 0, 1, 0);

    // Flush with an illegal word on the same cycle.
    step(32'hFFFF_FFFF, 1, 1, 1);
    step(32'h0000_0000, 0, 1, 0);
    check("count after flushed illegal", 32'(illegal_count), 32'h1);

    // Saturate the counter.
    for (int i = 0; i < CNT_MAX + 4; i++) step(32'hFFFF_FFFF, 1, 1, 0);
    step(32'h0000_0000, 0, 1, 0);
    check("count saturated", 32'(illegal_count), 32'(CNT_MAX));

    // Randomized traffic with a mid-stream asynchronous reset.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        step(rand_instr(), 1, 0, 0);
        step(32'h0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'h0);
        check("async reset illegal_count", 32'(illegal_count), 32'h0);
        sb.delete();
        mdl_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
      end
      step(rand_instr(), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    for (int i = 0; i < 4; i++) step(32'h0, 0, 1, 0);
    check("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
